counter_bcd_n: RTL and testbench
================================

COUNTER_BCD_N -- requirements
Module: counter_bcd_n

Interface
REQ-001 Parameter NUM_DIGITS, default 2, number of 4-bit BCD digits; legal range 1..8.
REQ-002 Parameter MAXCOUNT, width 4*NUM_DIGITS, default 'h59, BCD terminal value. Every digit SHALL be 0..9.
REQ-003 Clk  input  1  clock; all state updates on the rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Enable  input  1  count enable, active high.
REQ-006 Load  input  1  synchronous parallel-load strobe, active high.
REQ-007 LoadValue  input  4*NUM_DIGITS  BCD value to load.
REQ-008 Up  input  1  direction: 1 = up, 0 = down. Present only with COUNTER_BCD_N_DOWN_EN.
REQ-009 CurrentCount  output  4*NUM_DIGITS  registered BCD count.
REQ-010 TC  output  1  combinational terminal-count level.
REQ-011 RCO  output  1  combinational ripple carry out, TC AND Enable, for cascading.
REQ-012 Wrap  output  1  registered pulse, high for one cycle after a wrap.
REQ-013 LoadErr  output  1  registered pulse, high for one cycle after a rejected load.

Function
REQ-014 Priority per edge: Reset > Load > Enable > hold.
REQ-015 Up count, Enable=1, CurrentCount != MAXCOUNT: the count increments by 1 in BCD. A digit at 9 goes to 0 and carries into the next digit in the same edge.
REQ-016 Up count, Enable=1, CurrentCount == MAXCOUNT: the count goes to 0 and Wrap is set for the next cycle.
REQ-017 Down count, Enable=1, CurrentCount != 0: the count decrements by 1 in BCD. A digit at 0 goes to 9 and borrows from the next digit.
REQ-018 Down count, Enable=1, CurrentCount == 0: the count goes to MAXCOUNT and Wrap is set for the next cycle.
REQ-019 Terminal detection compares the whole count value, not digit by digit. TC = (CurrentCount == MAXCOUNT) when counting up, and (CurrentCount == 0) when counting down.
REQ-020 Load=1 with a valid LoadValue (every digit <= 9 and value <= MAXCOUNT): CurrentCount = LoadValue on the next edge, regardless of Enable. No Wrap.
REQ-021 Load=1 with an invalid LoadValue: the count holds, no count occurs that edge, and LoadErr is set for the next cycle.
REQ-022 Enable=0 and Load=0: the count holds. Wrap and LoadErr are 0 the next cycle.
REQ-023 A change of Up takes effect on the same edge. TC and RCO follow Up combinationally.
REQ-024 Latency: count, load and reset are visible one cycle after the sampling edge. Wrap and LoadErr coincide with the updated count.

Reset
REQ-025 Reset=1 at an edge: CurrentCount=0, Wrap=0, LoadErr=0, overriding Load and Enable.
REQ-026 Reset asserted mid-count discards all state. Counting resumes from 0 on the first edge with Reset=0.
REQ-027 Values after reset: TC=1 when counting down, TC=0 when counting up (MAXCOUNT != 0). RCO = TC AND Enable.

Configuration
REQ-028 Macro COUNTER_BCD_N_DOWN_EN: when defined, the Up port exists and down counting per REQ-017/018 is supported.
REQ-029 Without COUNTER_BCD_N_DOWN_EN: the Up port is absent, the block is up-count only, and it behaves as Up=1 everywhere.

Structure
REQ-030 Shared package counter_bcd_pkg SHALL hold: BCD digit type (4 bits), constant BCD_MAX_DIGIT=9, constant BCD_DIGIT_W=4, and a BCD-validity check function.
REQ-031 Sub-module bcd_digit SHALL implement one digit: inputs carry/borrow-in and direction; outputs next digit value and carry/borrow-out. It is instantiated NUM_DIGITS times in a generate loop.
REQ-032 The whole-value terminal/wrap compare and the load validity check live in counter_bcd_n, not in bcd_digit.

Verification
REQ-033 Defaults, Reset then Enable=1 for 60 cycles: count 00..59 then 00. Wrap pulses once, on the cycle showing 00. RCO high exactly at 59.
REQ-034 Load LoadValue='h37, Enable=1 same cycle: count = 37 next cycle, then 38. Load wins over Enable.
REQ-035 Load LoadValue='h5A, then 'h72: count unchanged both times. LoadErr pulses after each load.
REQ-036 NUM_DIGITS=3, MAXCOUNT='h999, count from 'h099 and from 'h999: 'h099 -> 'h100 (carry across digits); 'h999 -> 'h000 with Wrap.
REQ-037 COUNTER_BCD_N_DOWN_EN, Up=0, count from 'h10: 'h10 -> 'h09 -> ... -> 'h00 -> 'h59. TC=1 at 'h00. Wrap after 'h59 is loaded.
REQ-038 Reset=1 asserted at count 'h42 with Load=1 and Enable=1: next cycle count 'h00, Wrap=0, LoadErr=0.

Source files
------------

// File: rtl/counter_bcd_pkg.sv
// counter_bcd_pkg: shared BCD types, constants and helpers.
//   bcd_digit_t    one 4-bit BCD digit
//   BCD_DIGIT_W    digit width (4)
//   BCD_MAX_DIGIT  largest legal digit value (9)
//   bcd_valid()    checks that the low nd digits of a value are all 0..9
package counter_bcd_pkg;
  localparam int BCD_DIGIT_W    = 4;
  localparam int BCD_MAX_DIGITS = 8;

  typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;

  // Digits at position nd and above are ignored so one helper serves every width.
  function automatic logic bcd_valid(input logic [31:0] v, input int nd);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < BCD_MAX_DIGITS; i++)
      if (i < nd && v[i*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_MAX_DIGIT) ok = 1'b0;
    return ok;
  endfunction
endpackage

// File: rtl/counter_bcd_n_digit.sv
// bcd_digit: next-value logic for one BCD digit of the counter.
//   digit_i  current digit value
//   cin_i    carry-in (up) / borrow-in (down); the digit only moves when set
//   up_i     direction, 1 = increment, 0 = decrement
//   digit_o  next digit value
//   cout_o   carry-out (9 -> 0 going up) / borrow-out (0 -> 9 going down)
module bcd_digit
  import counter_bcd_pkg::*;
(
  input  bcd_digit_t digit_i,
  input  logic       cin_i,
  input  logic       up_i,
  output bcd_digit_t digit_o,
  output logic       cout_o
);
  always_comb begin
    digit_o = digit_i;
    cout_o  = 1'b0;
    if (cin_i) begin
      if (up_i) begin
        if (digit_i >= BCD_MAX_DIGIT) begin
          digit_o = '0;
          cout_o  = 1'b1;
        end else begin
          digit_o = digit_i + 4'd1;
        end
      end else begin
        if (digit_i == '0) begin
          digit_o = BCD_MAX_DIGIT;
          cout_o  = 1'b1;
        end else begin
          digit_o = digit_i - 4'd1;
        end
      end
    end
  end
endmodule

// File: rtl/counter_bcd_n.sv
// counter_bcd_n: N-digit BCD counter with terminal value MAXCOUNT, parallel
// load with validity check, and ripple carry out for cascading.
// Optional feature macro: COUNTER_BCD_N_DOWN_EN adds the Up port and down
// counting; without it the counter is up-only.
//   Clk           clock, rising edge
//   Reset         synchronous active-high reset
//   Enable        count enable
//   Load          parallel-load strobe (wins over Enable)
//   Up            direction, 1 = up (only with COUNTER_BCD_N_DOWN_EN)
//   LoadValue     BCD value to load
//   CurrentCount  registered BCD count
//   TC            combinational terminal-count level
//   RCO           TC & Enable
//   Wrap          one-cycle pulse after a wrap
//   LoadErr       one-cycle pulse after a rejected load
module counter_bcd_n
  import counter_bcd_pkg::*;
#(
  parameter int                       NUM_DIGITS = 2,
  parameter logic [4*NUM_DIGITS-1:0]  MAXCOUNT   = 'h59
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    Enable,
  input  logic                    Load,
`ifdef COUNTER_BCD_N_DOWN_EN
  input  logic                    Up,
`endif
  input  logic [4*NUM_DIGITS-1:0] LoadValue,
  output logic [4*NUM_DIGITS-1:0] CurrentCount,
  output logic                    TC,
  output logic                    RCO,
  output logic                    Wrap,
  output logic                    LoadErr
);
  localparam int W = BCD_DIGIT_W * NUM_DIGITS;

  logic up_w;
`ifdef COUNTER_BCD_N_DOWN_EN
  assign up_w = Up;
`else
  assign up_w = 1'b1;
`endif

  bcd_digit_t [NUM_DIGITS-1:0] cnt_q, cnt_d, nxt;
  logic                        wrap_q, wrap_d;
  logic                        lerr_q, lerr_d;
  logic [NUM_DIGITS:0]         carry;
  logic                        load_ok;
  logic                        unused_carry;

  // Digit 0 always steps; higher digits step on carry/borrow from below.
  assign carry[0] = 1'b1;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .digit_i (cnt_q[g]),
      .cin_i   (carry[g]),
      .up_i    (up_w),
      .digit_o (nxt[g]),
      .cout_o  (carry[g+1])
    );
  end

  // Wrap is decided by the whole-value compare, not by the top carry.
  assign unused_carry = carry[NUM_DIGITS];

  assign TC      = up_w ? (cnt_q == MAXCOUNT) : (cnt_q == '0);
  assign RCO     = TC & Enable;
  assign load_ok = bcd_valid(32'(LoadValue), NUM_DIGITS) && (LoadValue <= MAXCOUNT);

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    lerr_d = 1'b0;
    if (Load) begin
      if (load_ok) cnt_d  = LoadValue;
      else         lerr_d = 1'b1;
    end else if (Enable) begin
      if (TC) begin
        cnt_d  = up_w ? W'(0) : MAXCOUNT;
        wrap_d = 1'b1;
      end else begin
        cnt_d  = nxt;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
      lerr_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
      lerr_q <= lerr_d;
    end
  end

  assign CurrentCount = cnt_q;
  assign Wrap         = wrap_q;
  assign LoadErr      = lerr_q;
endmodule

// File: tb/tb_counter_bcd_n.sv
module tb_counter_bcd_n;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // default instance: 2 digits, terminal 59
  logic       rst, en, ld, up;
  logic [7:0] lv, cnt;
  logic       tc, rco, wrap, lerr;

  // 3-digit instance, terminal 999
  logic        rst1, en1, ld1;
  logic [11:0] lv1, cnt1;
  logic        tc1, rco1, wrap1, lerr1;

  counter_bcd_n u_dut (
    .Clk(clk), .Reset(rst), .Enable(en), .Load(ld),
`ifdef COUNTER_BCD_N_DOWN_EN
    .Up(up),
`endif
    .LoadValue(lv), .CurrentCount(cnt), .TC(tc), .RCO(rco),
    .Wrap(wrap), .LoadErr(lerr)
  );

  counter_bcd_n #(.NUM_DIGITS(3), .MAXCOUNT(12'h999)) u_dut3 (
    .Clk(clk), .Reset(rst1), .Enable(en1), .Load(ld1),
`ifdef COUNTER_BCD_N_DOWN_EN
    .Up(1'b1),
`endif
    .LoadValue(lv1), .CurrentCount(cnt1), .TC(tc1), .RCO(rco1),
    .Wrap(wrap1), .LoadErr(lerr1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] bcd2(input int v);
    return 32'(((v / 10) << 4) | (v % 10));
  endfunction

  initial begin
    rst = 1'b1; en = 1'b0; ld = 1'b0; up = 1'b1; lv = '0;
    rst1 = 1'b1; en1 = 1'b0; ld1 = 1'b0; lv1 = '0;
    tick();
    check("rst_cnt",  32'(cnt), 0);
    check("rst_wrap", 32'(wrap), 0);
    check("rst_lerr", 32'(lerr), 0);
    check("rst_tc",   32'(tc), 0);
    check("rst_rco",  32'(rco), 0);
    check("rst_cnt3", 32'(cnt1), 0);

    // free count 00..59 then 00
    rst = 1'b0; rst1 = 1'b0; en = 1'b1;
    for (int i = 0; i < 60; i++) begin
      check("seq_cnt",  32'(cnt), bcd2(i));
      check("seq_rco",  32'(rco), (i == 59) ? 1 : 0);
      check("seq_wrap", 32'(wrap), 0);
      tick();
    end
    check("wrap_cnt",  32'(cnt), 0);
    check("wrap_pls",  32'(wrap), 1);
    tick();
    check("after_wrap_cnt", 32'(cnt), 1);
    check("after_wrap_pls", 32'(wrap), 0);

    // load wins over enable
    ld = 1'b1; lv = 8'h37;
    tick();
    check("load37", 32'(cnt), 'h37);
    check("load37_wrap", 32'(wrap), 0);
    ld = 1'b0;
    tick();
    check("cnt38", 32'(cnt), 'h38);

    // rejected loads: bad digit, then above MAXCOUNT
    en = 1'b0; ld = 1'b1; lv = 8'h5A;
    tick();
    check("bad5A_cnt",  32'(cnt), 'h38);
    check("bad5A_lerr", 32'(lerr), 1);
    lv = 8'h72;
    tick();
    check("bad72_cnt",  32'(cnt), 'h38);
    check("bad72_lerr", 32'(lerr), 1);
    ld = 1'b0;
    tick();
    check("hold_cnt",  32'(cnt), 'h38);
    check("hold_lerr", 32'(lerr), 0);
    // boundary: loading exactly MAXCOUNT is legal
    ld = 1'b1; lv = 8'h59;
    tick();
    check("load59_cnt",  32'(cnt), 'h59);
    check("load59_lerr", 32'(lerr), 0);
    check("load59_tc",   32'(tc), 1);
    check("load59_rco0", 32'(rco), 0);
    ld = 1'b0; en = 1'b1;
    #1 check("load59_rco1", 32'(rco), 1);
    tick();
    check("wrap2_cnt", 32'(cnt), 0);
    check("wrap2_pls", 32'(wrap), 1);

    // reset beats load and enable
    en = 1'b0; ld = 1'b1; lv = 8'h42;
    tick();
    check("load42", 32'(cnt), 'h42);
    rst = 1'b1; ld = 1'b1; lv = 8'h37; en = 1'b1;
    tick();
    check("rst42_cnt",  32'(cnt), 0);
    check("rst42_wrap", 32'(wrap), 0);
    check("rst42_lerr", 32'(lerr), 0);
    rst = 1'b0; ld = 1'b0;
    tick();
    check("resume_cnt", 32'(cnt), 1);
    en = 1'b0;

    // 3-digit carry chain and wrap
    ld1 = 1'b1; lv1 = 12'h099;
    tick();
    check("d3_load099", 32'(cnt1), 'h099);
    ld1 = 1'b0; en1 = 1'b1;
    tick();
    check("d3_carry", 32'(cnt1), 'h100);
    en1 = 1'b0; ld1 = 1'b1; lv1 = 12'h999;
    tick();
    check("d3_load999", 32'(cnt1), 'h999);
    check("d3_tc",      32'(tc1), 1);
    ld1 = 1'b0; en1 = 1'b1;
    tick();
    check("d3_wrap_cnt", 32'(cnt1), 'h000);
    check("d3_wrap_pls", 32'(wrap1), 1);
    en1 = 1'b0; ld1 = 1'b1; lv1 = 12'h9A0;
    tick();
    check("d3_bad_cnt",  32'(cnt1), 'h000);
    check("d3_bad_lerr", 32'(lerr1), 1);
    check("d3_bad_wrap", 32'(wrap1), 0);
    ld1 = 1'b0;

`ifdef COUNTER_BCD_N_DOWN_EN
    // down count 10 -> 00 -> 59
    up = 1'b0; ld = 1'b1; lv = 8'h10;
    tick();
    ld = 1'b0; en = 1'b1;
    for (int i = 10; i >= 0; i--) begin
      check("dn_cnt", 32'(cnt), bcd2(i));
      check("dn_tc",  32'(tc), (i == 0) ? 1 : 0);
      tick();
    end
    check("dn_wrap_cnt", 32'(cnt), 'h59);
    check("dn_wrap_pls", 32'(wrap), 1);
    // direction change is seen combinationally on TC/RCO
    en = 1'b0; up = 1'b1;
    #1 check("dir_up_tc", 32'(tc), 1);
    up = 1'b0;
    #1 check("dir_dn_tc", 32'(tc), 0);
    up = 1'b1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
